// File: rtl/fluid_pkg.sv
// ---------------------------------------------------------------------------
// fluid_pkg
//   Shared types and helpers for the fluid-simulation projection pipeline.
//   - vel_t  : signed Q16.16 face velocity
//   - face_t : RAM face word {open flag, velocity}
//   - recip_q16 : 1/n in unsigned Q16.16 for n = 1..4 open faces
//   - sat32  : clamp a wide signed value into vel_t
//   - face_addr : linear face-RAM address (col + row*stride), shared with the
//                 read stage so both sides agree on the RAM layout
// ---------------------------------------------------------------------------
package fluid_pkg;

    localparam int FRAC_BITS = 16;

    typedef logic signed [31:0] vel_t;

    typedef struct packed {
        logic open;
        vel_t vel;
    } face_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIV,
        S_RECIP,
        S_RELAX,
        S_WR_SIDE1,
        S_WR_SIDE0,
        S_FINISH
    } cell_state_t;

    localparam logic signed [63:0] SAT_MAX = 64'sd2147483647;
    localparam logic signed [63:0] SAT_MIN = -64'sd2147483648;

    // Reciprocal of the open-face count; n outside 1..4 yields no correction.
    function automatic logic [16:0] recip_q16(input logic [2:0] n);
        case (n)
            3'd1:    return 17'd65536;
            3'd2:    return 17'd32768;
            3'd3:    return 17'd21845;
            3'd4:    return 17'd16384;
            default: return 17'd0;
        endcase
    endfunction

    function automatic vel_t sat32(input logic signed [63:0] v);
        if (v > SAT_MAX) return 32'sh7FFF_FFFF;
        if (v < SAT_MIN) return 32'sh8000_0000;
        return v[31:0];
    endfunction

    // A closed face contributes nothing to the divergence.
    function automatic logic signed [33:0] face_contrib(input face_t f);
        return f.open ? 34'($signed(f.vel)) : 34'sd0;
    endfunction

    function automatic logic [31:0] face_addr(input logic [31:0] col,
                                              input logic [31:0] row,
                                              input logic [31:0] stride);
        return col + row * stride;
    endfunction

endpackage

// File: rtl/project_cell.sv
// ---------------------------------------------------------------------------
// project_cell
//   One projection step for a single cell: computes the over-relaxed
//   divergence correction from the four face velocities and writes the
//   corrected faces back to the h-face and v-face velocity RAMs.
//
//   Timeline after the start edge k:
//     DIV(k+1) RECIP(k+2) RELAX(k+3) WR_SIDE1(k+4) WR_SIDE0(k+5) FINISH(k+6)
//   A cell with no open faces skips straight from DIV to FINISH.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle request, only honoured in IDLE
//   field_x, field_y    cell column / row
//   vx1, vx2, vy1, vy2  face words (left, right, low, high)
//   n                   number of open faces (0..4)
//   h_vel_*             h-face RAM write port (addr, data, we)
//   v_vel_*             v-face RAM write port (addr, data, we)
//   busy                high outside IDLE
//   done                one-cycle completion pulse
// ---------------------------------------------------------------------------
module project_cell
    import fluid_pkg::*;
#(
    parameter int          FIELD_WIDTH  = 8,
    parameter int          FIELD_HEIGHT = 6,
    parameter int          H_VEL_WIDTH  = FIELD_WIDTH - 1,
    parameter int          V_VEL_WIDTH  = FIELD_WIDTH,
    parameter int          H_VEL_ADDRW  = $clog2(H_VEL_WIDTH * FIELD_HEIGHT),
    parameter int          V_VEL_ADDRW  = $clog2(V_VEL_WIDTH * (FIELD_HEIGHT - 1)),
    parameter int          VEL_DATAW    = 33,
    parameter logic [31:0] OVERRELAX    = 32'h0001_C000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [31:0]            field_x,
    input  logic [31:0]            field_y,
    input  logic [VEL_DATAW-1:0]   vx1,
    input  logic [VEL_DATAW-1:0]   vx2,
    input  logic [VEL_DATAW-1:0]   vy1,
    input  logic [VEL_DATAW-1:0]   vy2,
    input  logic [2:0]             n,
    output logic [H_VEL_ADDRW-1:0] h_vel_addr_write,
    output logic [VEL_DATAW-1:0]   h_vel_data_in,
    output logic                   h_vel_we,
    output logic [V_VEL_ADDRW-1:0] v_vel_addr_write,
    output logic [VEL_DATAW-1:0]   v_vel_data_in,
    output logic                   v_vel_we,
    output logic                   busy,
    output logic                   done
);

    cell_state_t r_state, w_next;

    // Latched request
    logic [31:0] r_x, r_y;
    face_t       r_vx1, r_vx2, r_vy1, r_vy2;
    logic [2:0]  r_n;

    // Pipeline of the correction term, one multiply per cycle
    logic signed [33:0] r_div, r_q;
    vel_t               r_corr;

    logic signed [33:0] w_div;
    logic signed [51:0] w_prod;
    logic signed [66:0] w_prod2;
    vel_t               w_corr;

    logic signed [63:0] w_sum_h1, w_sum_v1, w_sum_h0, w_sum_v0;
    logic [31:0]        w_addr_h1, w_addr_v1, w_addr_h0, w_addr_v0;

    // ------------------------------------------------------------------
    // Arithmetic
    // ------------------------------------------------------------------
    assign w_div = face_contrib(r_vx2) - face_contrib(r_vx1)
                 + face_contrib(r_vy2) - face_contrib(r_vy1);

    // |div| < 2^33 and 1/n <= 1.0, so the product fits in 50 bits and
    // bits [49:16] are exactly (div*recip) >>> 16.
    assign w_prod  = 52'(r_div) * $signed({35'd0, recip_q16(r_n)});

    // q * OVERRELAX can exceed 32 bits after the shift; clamp rather than wrap.
    assign w_prod2 = 67'(r_q) * $signed({35'd0, OVERRELAX});
    assign w_corr  = sat32(64'($signed(w_prod2[66:FRAC_BITS])));

    // Low-side faces gain the correction, high-side faces lose it.
    assign w_sum_h1 = 64'($signed(r_vx1.vel)) + 64'($signed(r_corr));
    assign w_sum_v1 = 64'($signed(r_vy1.vel)) + 64'($signed(r_corr));
    assign w_sum_h0 = 64'($signed(r_vx2.vel)) - 64'($signed(r_corr));
    assign w_sum_v0 = 64'($signed(r_vy2.vel)) - 64'($signed(r_corr));

    assign w_addr_h1 = face_addr(r_x - 32'd1, r_y,         32'(H_VEL_WIDTH));
    assign w_addr_v1 = face_addr(r_x,         r_y - 32'd1, 32'(V_VEL_WIDTH));
    assign w_addr_h0 = face_addr(r_x,         r_y,         32'(H_VEL_WIDTH));
    assign w_addr_v0 = face_addr(r_x,         r_y,         32'(V_VEL_WIDTH));

    // Bits dropped by the fixed-point shifts and address truncation.
    logic w_unused_bits;
    assign w_unused_bits = ^{w_prod[51:50], w_prod[15:0], w_prod2[15:0],
                             w_addr_h1[31:H_VEL_ADDRW], w_addr_h0[31:H_VEL_ADDRW],
                             w_addr_v1[31:V_VEL_ADDRW], w_addr_v0[31:V_VEL_ADDRW]};

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next           = r_state;
        h_vel_we         = 1'b0;
        h_vel_addr_write = '0;
        h_vel_data_in    = '0;
        v_vel_we         = 1'b0;
        v_vel_addr_write = '0;
        v_vel_data_in    = '0;
        busy             = (r_state != S_IDLE);
        done             = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_next = S_DIV;
            S_DIV:   w_next = (r_n == 3'd0) ? S_FINISH : S_RECIP;
            S_RECIP: w_next = S_RELAX;
            S_RELAX: w_next = S_WR_SIDE1;
            S_WR_SIDE1: begin
                w_next           = S_WR_SIDE0;
                // Left/low faces on the field border have no RAM slot.
                h_vel_we         = r_vx1.open && (r_x != 32'd0);
                h_vel_addr_write = w_addr_h1[H_VEL_ADDRW-1:0];
                h_vel_data_in    = {1'b1, sat32(w_sum_h1)};
                v_vel_we         = r_vy1.open && (r_y != 32'd0);
                v_vel_addr_write = w_addr_v1[V_VEL_ADDRW-1:0];
                v_vel_data_in    = {1'b1, sat32(w_sum_v1)};
            end
            S_WR_SIDE0: begin
                w_next           = S_FINISH;
                h_vel_we         = r_vx2.open && (r_x != 32'(FIELD_WIDTH - 1));
                h_vel_addr_write = w_addr_h0[H_VEL_ADDRW-1:0];
                h_vel_data_in    = {1'b1, sat32(w_sum_h0)};
                v_vel_we         = r_vy2.open && (r_y != 32'(FIELD_HEIGHT - 1));
                v_vel_addr_write = w_addr_v0[V_VEL_ADDRW-1:0];
                v_vel_data_in    = {1'b1, sat32(w_sum_v0)};
            end
            S_FINISH: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_vx1  <= '0;
            r_vx2  <= '0;
            r_vy1  <= '0;
            r_vy2  <= '0;
            r_n    <= '0;
            r_div  <= '0;
            r_q    <= '0;
            r_corr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x   <= field_x;
                        r_y   <= field_y;
                        r_vx1 <= vx1;
                        r_vx2 <= vx2;
                        r_vy1 <= vy1;
                        r_vy2 <= vy2;
                        r_n   <= n;
                    end
                end
                S_DIV:   r_div  <= w_div;
                S_RECIP: r_q    <= w_prod[49:16];
                S_RELAX: r_corr <= w_corr;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_project_cell.sv
// Self-checking bench for project_cell. Two instances share all inputs: one
// with the default over-relaxation (1.75) and one with 1.0. Each transaction
// is captured for seven cycles after the start edge and compared against a
// plain-arithmetic reference model.
module tb_project_cell;

    typedef struct packed {
        logic        hwe;
        logic [5:0]  ha;
        logic [32:0] hd;
        logic        vwe;
        logic [5:0]  va;
        logic [32:0] vd;
        logic        done;
        logic        busy;
    } snap_t;

    typedef struct {
        logic [31:0] x, y;
        logic [32:0] vx1, vx2, vy1, vy2;
        logic [2:0]  n;
    } cell_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] field_x = '0, field_y = '0;
    logic [32:0] vx1 = '0, vx2 = '0, vy1 = '0, vy2 = '0;
    logic [2:0]  n = '0;

    logic [1:0][5:0]  h_addr, v_addr;
    logic [1:0][32:0] h_data, v_data;
    logic [1:0]       h_we, v_we, busy, done;

    int n_pass = 0;
    int n_chk  = 0;

    snap_t obs  [2][8];
    snap_t expv [2][8];

    always #5 clk = ~clk;

    project_cell u_dut0 (
        .clk(clk), .rst(rst), .start(start), .field_x(field_x), .field_y(field_y),
        .vx1(vx1), .vx2(vx2), .vy1(vy1), .vy2(vy2), .n(n),
        .h_vel_addr_write(h_addr[0]), .h_vel_data_in(h_data[0]), .h_vel_we(h_we[0]),
        .v_vel_addr_write(v_addr[0]), .v_vel_data_in(v_data[0]), .v_vel_we(v_we[0]),
        .busy(busy[0]), .done(done[0])
    );

    project_cell #(.OVERRELAX(32'h0001_0000)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .field_x(field_x), .field_y(field_y),
        .vx1(vx1), .vx2(vx2), .vy1(vy1), .vy2(vy2), .n(n),
        .h_vel_addr_write(h_addr[1]), .h_vel_data_in(h_data[1]), .h_vel_we(h_we[1]),
        .v_vel_addr_write(v_addr[1]), .v_vel_data_in(v_data[1]), .v_vel_we(v_we[1]),
        .busy(busy[1]), .done(done[1])
    );

    // ---------------- reference model ----------------
    function automatic longint satl(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic longint sval(input logic [32:0] f);
        return longint'($signed(f[31:0]));
    endfunction

    task automatic model(input cell_t t, input int d);
        longint ovr, dv, rc, q, cr;
        int     x, y;
        ovr = (d == 0) ? 64'sd114688 : 64'sd65536;   // 1.75 / 1.0 in Q16.16
        dv  = (t.vx2[32] ? sval(t.vx2) : 0) - (t.vx1[32] ? sval(t.vx1) : 0)
            + (t.vy2[32] ? sval(t.vy2) : 0) - (t.vy1[32] ? sval(t.vy1) : 0);
        case (t.n)
            3'd1: rc = 65536;
            3'd2: rc = 32768;
            3'd3: rc = 21845;
            3'd4: rc = 16384;
            default: rc = 0;
        endcase
        q  = (dv * rc) >>> 16;
        cr = satl((q * ovr) >>> 16);
        x  = int'(t.x);
        y  = int'(t.y);
        for (int c = 0; c < 8; c++) expv[d][c] = '0;
        if (t.n == 3'd0) begin
            expv[d][1].busy = 1'b1;
            expv[d][2].busy = 1'b1;
            expv[d][2].done = 1'b1;
        end else begin
            for (int c = 1; c <= 6; c++) expv[d][c].busy = 1'b1;
            expv[d][6].done = 1'b1;
            expv[d][4].hwe = t.vx1[32] && (x != 0);
            expv[d][4].ha  = 6'((x - 1) + y * 7);
            expv[d][4].hd  = {1'b1, 32'(satl(sval(t.vx1) + cr))};
            expv[d][4].vwe = t.vy1[32] && (y != 0);
            expv[d][4].va  = 6'(x + (y - 1) * 8);
            expv[d][4].vd  = {1'b1, 32'(satl(sval(t.vy1) + cr))};
            expv[d][5].hwe = t.vx2[32] && (x != 7);
            expv[d][5].ha  = 6'(x + y * 7);
            expv[d][5].hd  = {1'b1, 32'(satl(sval(t.vx2) - cr))};
            expv[d][5].vwe = t.vy2[32] && (y != 5);
            expv[d][5].va  = 6'(x + y * 8);
            expv[d][5].vd  = {1'b1, 32'(satl(sval(t.vy2) - cr))};
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic snap_t snap(input int d);
        snap_t s;
        s.hwe = h_we[d];  s.ha = h_addr[d]; s.hd = h_data[d];
        s.vwe = v_we[d];  s.va = v_addr[d]; s.vd = v_data[d];
        s.done = done[d]; s.busy = busy[d];
        return s;
    endfunction

    function automatic cell_t mk(input int x, input int y, input logic [32:0] a,
                                 input logic [32:0] b, input logic [32:0] c,
                                 input logic [32:0] e, input int nn);
        cell_t t;
        t.x = 32'(x); t.y = 32'(y);
        t.vx1 = a; t.vx2 = b; t.vy1 = c; t.vy2 = e;
        t.n = 3'(nn);
        return t;
    endfunction

    function automatic logic [32:0] rand_face();
        logic [32:0] f;
        f[32] = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 2))
            0:       f[31:0] = $urandom_range(0, 32'h7FFFF) - 32'h40000;
            1:       f[31:0] = $urandom;
            default: f[31:0] = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        endcase
        return f;
    endfunction

    function automatic cell_t rand_cell();
        cell_t t;
        t.x   = $urandom_range(0, 7);
        t.y   = $urandom_range(0, 5);
        t.vx1 = rand_face(); t.vx2 = rand_face();
        t.vy1 = rand_face(); t.vy2 = rand_face();
        t.n   = 3'(int'(t.vx1[32]) + int'(t.vx2[32]) + int'(t.vy1[32]) + int'(t.vy2[32]));
        return t;
    endfunction

    // Called at a negedge: drives the request so it is sampled on the next
    // posedge (edge k), then scrambles the inputs, which must have no effect.
    task automatic launch(input cell_t t, input bit hold);
        field_x = t.x; field_y = t.y;
        vx1 = t.vx1; vx2 = t.vx2; vy1 = t.vy1; vy2 = t.vy2; n = t.n;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        field_x = $urandom; field_y = $urandom;
        vx1 = {1'($urandom), $urandom}; vx2 = {1'($urandom), $urandom};
        vy1 = {1'($urandom), $urandom}; vy2 = {1'($urandom), $urandom};
        n = 3'($urandom);
    endtask

    // obs[d][c] is what the RAM sees at edge k+c.
    task automatic capture(input bit hold);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            obs[0][c] = snap(0);
            obs[1][c] = snap(1);
            if (hold && c == 6) start = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (snap(d) !== '0)
                    $display("FAIL reset dut%0d step%0d got %h want 0", d, r, snap(d));
                else n_pass++;
            end
            rst = 1'b0;
        end
    endtask

    task automatic test_directed();
        cell_t tbl [7];
        tbl[0] = mk(3, 2, {1'b1, 32'h0001_0000}, {1'b1, 32'h0003_0000}, {1'b1, 32'h0}, {1'b1, 32'h0}, 4);
        tbl[1] = mk(0, 2, {1'b0, 32'h0005_0000}, {1'b1, 32'h0003_0000}, {1'b1, 32'h0}, {1'b1, 32'h0}, 3);
        tbl[2] = mk(7, 5, {1'b1, 32'h0000_5000}, {1'b0, 32'h0001_0000}, {1'b1, 32'h0000_1234}, {1'b0, 32'h0002_0000}, 2);
        tbl[3] = mk(2, 1, {1'b1, 32'h0001_0000}, {1'b1, 32'h0009_0000}, {1'b1, 32'h0}, {1'b1, 32'h4}, 0);
        tbl[4] = mk(3, 2, {1'b1, 32'h8001_0000}, {1'b1, 32'h7FFF_0000}, {1'b0, 32'h0}, {1'b0, 32'h0}, 2);
        tbl[5] = mk(3, 2, {1'b1, 32'h7FFF_0000}, {1'b1, 32'h7FFF_FFFF}, {1'b1, 32'h8000_0000}, {1'b1, 32'h7FFF_FFFF}, 4);
        tbl[6] = mk(0, 0, {1'b1, 32'hFFFF_0000}, {1'b1, 32'h0000_8000}, {1'b1, 32'h0002_0000}, {1'b1, 32'hFFFE_0000}, 4);
        for (int i = 0; i < 7; i++) begin
            model(tbl[i], 0);
            model(tbl[i], 1);
            launch(tbl[i], 1'b0);
            capture(1'b0);
            for (int d = 0; d < 2; d++)
                for (int c = 1; c <= 7; c++) begin
                    n_chk++;
                    if ({obs[d][c].hwe, obs[d][c].vwe, obs[d][c].done, obs[d][c].busy} !==
                        {expv[d][c].hwe, expv[d][c].vwe, expv[d][c].done, expv[d][c].busy})
                        $display("FAIL directed%0d dut%0d c%0d ctl(hwe,vwe,done,busy) got %b want %b", i, d, c,
                                 {obs[d][c].hwe, obs[d][c].vwe, obs[d][c].done, obs[d][c].busy},
                                 {expv[d][c].hwe, expv[d][c].vwe, expv[d][c].done, expv[d][c].busy});
                    else n_pass++;
                    if (expv[d][c].hwe) begin
                        n_chk++;
                        if ({obs[d][c].ha, obs[d][c].hd} !== {expv[d][c].ha, expv[d][c].hd})
                            $display("FAIL directed%0d dut%0d c%0d h addr/data got %0d/%h want %0d/%h", i, d, c,
                                     obs[d][c].ha, obs[d][c].hd, expv[d][c].ha, expv[d][c].hd);
                        else n_pass++;
                    end
                    if (expv[d][c].vwe) begin
                        n_chk++;
                        if ({obs[d][c].va, obs[d][c].vd} !== {expv[d][c].va, expv[d][c].vd})
                            $display("FAIL directed%0d dut%0d c%0d v addr/data got %0d/%h want %0d/%h", i, d, c,
                                     obs[d][c].va, obs[d][c].vd, expv[d][c].va, expv[d][c].vd);
                        else n_pass++;
                    end
                end
            // Hand-computed anchors, independent of the model.
            if (i == 0) begin
                n_chk++;
                if ({obs[1][4].hwe, obs[1][4].ha, obs[1][4].hd, obs[1][4].vwe, obs[1][4].va, obs[1][4].vd} !==
                    {1'b1, 6'd16, 33'h1_0001_8000, 1'b1, 6'd11, 33'h1_0000_8000})
                    $display("FAIL anchor_side1 got %h/%h want 16/100018000 11/100008000", obs[1][4].ha, obs[1][4].hd);
                else n_pass++;
                n_chk++;
                if ({obs[1][5].hwe, obs[1][5].ha, obs[1][5].hd, obs[1][5].vwe, obs[1][5].va, obs[1][5].vd} !==
                    {1'b1, 6'd17, 33'h1_0002_8000, 1'b1, 6'd19, 33'h1_FFFF_8000})
                    $display("FAIL anchor_side0 got %h/%h %h/%h want 17/100028000 19/1ffff8000",
                             obs[1][5].ha, obs[1][5].hd, obs[1][5].va, obs[1][5].vd);
                else n_pass++;
            end
            if (i == 1) begin
                n_chk++;
                if ({obs[1][4].hwe, obs[1][5].hwe, obs[1][5].hd} !== {1'b0, 1'b1, 33'h1_0002_0001})
                    $display("FAIL anchor_closed got %b%b %h want 01 100020001", obs[1][4].hwe, obs[1][5].hwe, obs[1][5].hd);
                else n_pass++;
            end
            if (i == 3) begin
                n_chk++;
                if ({obs[0][2].done, obs[0][3].busy} !== 2'b10)
                    $display("FAIL anchor_n0 done@2/busy@3 got %b%b want 10", obs[0][2].done, obs[0][3].busy);
                else n_pass++;
            end
            if (i == 4) begin
                n_chk++;
                if ({obs[0][4].hd, obs[0][5].hd} !== {33'h1_0000_FFFF, 33'h1_FFFF_0001})
                    $display("FAIL anchor_corr_sat got %h %h want 10000ffff 1ffff0001", obs[0][4].hd, obs[0][5].hd);
                else n_pass++;
            end
            if (i == 5) begin
                n_chk++;
                if ({obs[0][4].hd, obs[1][4].hd} !== {33'h1_7FFF_FFFF, 33'h1_7FFF_FFFF})
                    $display("FAIL anchor_write_sat got %h %h want 17fffffff", obs[0][4].hd, obs[1][4].hd);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        cell_t t;
        for (int i = 0; i < 40; i++) begin
            t = rand_cell();
            model(t, 0);
            model(t, 1);
            launch(t, 1'b0);
            capture(1'b0);
            for (int d = 0; d < 2; d++)
                for (int c = 1; c <= 7; c++) begin
                    n_chk++;
                    if ({obs[d][c].hwe, obs[d][c].vwe, obs[d][c].done, obs[d][c].busy} !==
                        {expv[d][c].hwe, expv[d][c].vwe, expv[d][c].done, expv[d][c].busy})
                        $display("FAIL random%0d dut%0d c%0d ctl got %b want %b", i, d, c,
                                 {obs[d][c].hwe, obs[d][c].vwe, obs[d][c].done, obs[d][c].busy},
                                 {expv[d][c].hwe, expv[d][c].vwe, expv[d][c].done, expv[d][c].busy});
                    else n_pass++;
                    if (expv[d][c].hwe) begin
                        n_chk++;
                        if ({obs[d][c].ha, obs[d][c].hd} !== {expv[d][c].ha, expv[d][c].hd})
                            $display("FAIL random%0d dut%0d c%0d h got %0d/%h want %0d/%h", i, d, c,
                                     obs[d][c].ha, obs[d][c].hd, expv[d][c].ha, expv[d][c].hd);
                        else n_pass++;
                    end
                    if (expv[d][c].vwe) begin
                        n_chk++;
                        if ({obs[d][c].va, obs[d][c].vd} !== {expv[d][c].va, expv[d][c].vd})
                            $display("FAIL random%0d dut%0d c%0d v got %0d/%h want %0d/%h", i, d, c,
                                     obs[d][c].va, obs[d][c].vd, expv[d][c].va, expv[d][c].vd);
                        else n_pass++;
                    end
                end
        end
    endtask

    // start held high (with changing inputs) through the whole operation,
    // including FINISH; none of it may be taken as a new request.
    task automatic test_busy_ignore();
        cell_t t;
        t = mk(4, 3, {1'b1, 32'h0002_0000}, {1'b1, 32'hFFFF_0000}, {1'b1, 32'h0000_4000}, {1'b1, 32'h0001_8000}, 4);
        model(t, 0);
        model(t, 1);
        launch(t, 1'b1);
        capture(1'b1);
        for (int d = 0; d < 2; d++)
            for (int c = 1; c <= 7; c++) begin
                n_chk++;
                if ({obs[d][c].hwe, obs[d][c].vwe, obs[d][c].done, obs[d][c].busy} !==
                    {expv[d][c].hwe, expv[d][c].vwe, expv[d][c].done, expv[d][c].busy})
                    $display("FAIL busy_ignore dut%0d c%0d ctl got %b want %b", d, c,
                             {obs[d][c].hwe, obs[d][c].vwe, obs[d][c].done, obs[d][c].busy},
                             {expv[d][c].hwe, expv[d][c].vwe, expv[d][c].done, expv[d][c].busy});
                else n_pass++;
                if (expv[d][c].hwe || expv[d][c].vwe) begin
                    n_chk++;
                    if ({obs[d][c].hd, obs[d][c].vd} !== {expv[d][c].hd, expv[d][c].vd})
                        $display("FAIL busy_ignore dut%0d c%0d data got %h/%h want %h/%h", d, c,
                                 obs[d][c].hd, obs[d][c].vd, expv[d][c].hd, expv[d][c].vd);
                    else n_pass++;
                end
            end
    endtask

    // Reset sampled at edge k+3; nothing may be written afterwards; a new
    // start at edge k+5 completes with done at edge k+11.
    task automatic test_reset_mid();
        cell_t t, t2;
        t  = mk(3, 2, {1'b1, 32'h0001_0000}, {1'b1, 32'h0003_0000}, {1'b1, 32'h0}, {1'b1, 32'h0}, 4);
        t2 = mk(5, 1, {1'b1, 32'h0000_8000}, {1'b1, 32'h0004_0000}, {1'b1, 32'hFFFF_0000}, {1'b0, 32'h0}, 3);
        launch(t, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_chk++;
                if (c <= 3 ? (snap(d).busy !== 1'b1)
                           : ({snap(d).hwe, snap(d).vwe, snap(d).done, snap(d).busy} !== 4'b0000))
                    $display("FAIL reset_mid dut%0d c%0d ctl got %b want %s", d, c,
                             {snap(d).hwe, snap(d).vwe, snap(d).done, snap(d).busy}, c <= 3 ? "busy" : "0000");
                else n_pass++;
            end
            if (c == 3) rst = 1'b1;
            if (c == 4) rst = 1'b0;
        end
        model(t2, 0);
        model(t2, 1);
        launch(t2, 1'b0);
        capture(1'b0);
        for (int d = 0; d < 2; d++)
            for (int c = 1; c <= 7; c++) begin
                n_chk++;
                if ({obs[d][c].hwe, obs[d][c].vwe, obs[d][c].done, obs[d][c].busy} !==
                    {expv[d][c].hwe, expv[d][c].vwe, expv[d][c].done, expv[d][c].busy})
                    $display("FAIL reset_restart dut%0d c%0d ctl got %b want %b", d, c,
                             {obs[d][c].hwe, obs[d][c].vwe, obs[d][c].done, obs[d][c].busy},
                             {expv[d][c].hwe, expv[d][c].vwe, expv[d][c].done, expv[d][c].busy});
                else n_pass++;
                if (expv[d][c].hwe || expv[d][c].vwe) begin
                    n_chk++;
                    if ({obs[d][c].hd, obs[d][c].vd} !== {expv[d][c].hd, expv[d][c].vd})
                        $display("FAIL reset_restart dut%0d c%0d data got %h/%h want %h/%h", d, c,
                                 obs[d][c].hd, obs[d][c].vd, expv[d][c].hd, expv[d][c].vd);
                    else n_pass++;
                end
            end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
